// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and slot match helper for the execute-stage hazard sequencer
package hazard_pkg;

    // Slot rd is stored at this width; narrower register indices are zero-extended into it.
    localparam int HZ_RD_W = 8;

    typedef logic [HZ_RD_W-1:0] hz_rd_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_src_t;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_LSTALL = 2'd1,
        HZ_FLUSH  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic   v;
        hz_rd_t rd;
        logic   we;
        logic   load;
    } slot_t;

    // x0 is hardwired, so a write to it never produces a forwardable value.
    function automatic logic slot_match(input slot_t s, input hz_rd_t rs, input logic used);
        return s.v && s.we && (s.rd != '0) && (s.rd == rs) && used;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding source select, EX result preferred over MEM result
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic             used_i,
    input  slot_t            ex_slot_i,
    input  slot_t            mem_slot_i,
    output fwd_src_t         src_o
);

    hz_rd_t rs_ext;
    logic   unused_load;

    assign rs_ext      = hz_rd_t'(rs_i);
    assign unused_load = ex_slot_i.load ^ mem_slot_i.load;

    always_comb begin
        src_o = FWD_REG;
        if (slot_match(ex_slot_i, rs_ext, used_i)) begin
            src_o = FWD_EX;
        end else if (slot_match(mem_slot_i, rs_ext, used_i)) begin
            src_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - execute-stage issue/forwarding sequencer with load-use stall and redirect flush
// Optional HAZARD_PERF_EN adds perf_stall_cnt/perf_flush_cnt cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_reg_we,
    input  logic             dec_load,
    input  logic             redirect,
    output logic             issue,
    output logic             stall,
    output logic [1:0]       alu_a_src,
    output logic [1:0]       alu_b_src,
    output logic             flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t        state_q, state_d;
    logic             issue_q, issue_d;
    fwd_src_t         a_src_q, a_src_d;
    fwd_src_t         b_src_q, b_src_d;
    slot_t            ex_slot_q, ex_slot_d;
    slot_t            mem_slot_q, mem_slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fwd_src_t a_fwd, b_fwd;
    slot_t    dec_slot;
    logic     load_use;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs_i       (dec_rs1),
        .used_i     (dec_rs1_used),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .src_o      (a_fwd)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs_i       (dec_rs2),
        .used_i     (dec_rs2_used),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .src_o      (b_fwd)
    );

    // A load in EX has no result yet, so an EX match on a load cannot be forwarded.
    assign load_use = (state_q == HZ_RUN) && dec_valid && ex_slot_q.load &&
                      ((a_fwd == FWD_EX) || (b_fwd == FWD_EX));

    always_comb begin
        dec_slot.v    = 1'b1;
        dec_slot.rd   = hz_rd_t'(dec_rd);
        dec_slot.we   = dec_reg_we;
        dec_slot.load = dec_load;
    end

    always_comb begin
        state_d    = state_q;
        issue_d    = 1'b0;
        a_src_d    = FWD_REG;
        b_src_d    = FWD_REG;
        ex_slot_d  = '0;
        mem_slot_d = ex_slot_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        flush      = (state_q == HZ_FLUSH);

        if (redirect) begin
            // The branch is older than the wrong-path instruction, so MEM keeps its contents.
            state_d    = HZ_FLUSH;
            cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
            mem_slot_d = mem_slot_q;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (load_use) begin
                        stall   = 1'b1;
                        state_d = HZ_LSTALL;
                    end else begin
                        issue_d = dec_valid;
                        if (dec_valid) begin
                            ex_slot_d = dec_slot;
                            a_src_d   = a_fwd;
                            b_src_d   = b_fwd;
                        end
                    end
                end
                HZ_LSTALL: begin
                    issue_d   = 1'b1;
                    ex_slot_d = dec_slot;
                    a_src_d   = a_fwd;
                    b_src_d   = b_fwd;
                    state_d   = HZ_RUN;
                end
                HZ_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = HZ_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HZ_RUN;
            issue_q    <= 1'b0;
            a_src_q    <= FWD_REG;
            b_src_q    <= FWD_REG;
            ex_slot_q  <= '0;
            mem_slot_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            a_src_q    <= a_src_d;
            b_src_q    <= b_src_d;
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= mem_slot_d;
            cnt_q      <= cnt_d;
        end
    end

    assign issue     = issue_q;
    assign alu_a_src = a_src_q;
    assign alu_b_src = b_src_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (state_q == HZ_LSTALL) perf_stall_q <= perf_stall_q + 32'd1;
            if (state_q == HZ_FLUSH)  perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a pipeline-history reference model
module tb_hazard_ctrl;

    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic       dec_rs1_used = 1'b0, dec_rs2_used = 1'b0;
    logic       dec_reg_we = 1'b0, dec_load = 1'b0, redirect = 1'b0;
    logic       issue, stall, flush;
    logic [1:0] alu_a_src, alu_b_src;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_reg_we   (dec_reg_we),
        .dec_load     (dec_load),
        .redirect     (redirect),
        .issue        (issue),
        .stall        (stall),
        .alu_a_src    (alu_a_src),
        .alu_b_src    (alu_b_src),
        .flush        (flush)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } rec_t;

    typedef struct {
        bit issue;
        bit flush;
        bit stall;
        bit chk_src;
        int a;
        int b;
        int sc;
        int fc;
    } exp_t;

    exp_t sbq[$];
    rec_t hist[$];
    int   checks = 0;
    int   failures = 0;

    int cyc = 0;
    int flush_end = -1;
    bit after_load = 1'b0;
    bit post_rst = 1'b1;
    bit m_issue = 1'b0;
    int m_a = 0, m_b = 0;
    int m_sc = 0, m_fc = 0;
    bit prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit hits(input rec_t s, input int rs, input bit used);
        return used && rs != 0 && s.v && s.we && s.rd == rs;
    endfunction

    function automatic int fwd(input int rs, input bit used);
        if (hits(hist[0], rs, used)) return 1;
        if (hits(hist[1], rs, used)) return 2;
        return 0;
    endfunction

    function automatic void hist_push(input rec_t r);
        hist.push_front(r);
        void'(hist.pop_back());
    endfunction

    function automatic void model_reset();
        rec_t bub;
        bub = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        hist.delete();
        hist.push_back(bub);
        hist.push_back(bub);
        flush_end  = -1;
        after_load = 1'b0;
        post_rst   = 1'b1;
        m_issue    = 1'b0;
        m_a        = 0;
        m_b        = 0;
        m_sc       = 0;
        m_fc       = 0;
    endfunction

    // Expected outputs for the current cycle go to the scoreboard, then the model advances one cycle.
    function automatic void model_step();
        exp_t e;
        rec_t r;
        bit   inf, lu, iss;
        inf = (cyc <= flush_end);
        lu  = !inf && !after_load && dec_valid && hist[0].v && hist[0].ld &&
              (hits(hist[0], dec_rs1, dec_rs1_used) || hits(hist[0], dec_rs2, dec_rs2_used));
        e.issue   = m_issue;
        e.flush   = inf;
        e.stall   = lu && !redirect;
        e.chk_src = m_issue || post_rst;
        e.a       = m_a;
        e.b       = m_b;
        e.sc      = m_sc;
        e.fc      = m_fc;
        sbq.push_back(e);
        prev_stall = e.stall;
        r = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        if (reset) begin
            model_reset();
        end else begin
            post_rst = 1'b0;
            m_sc += int'(after_load);
            m_fc += int'(inf);
            m_issue = 1'b0;
            m_a = 0;
            m_b = 0;
            if (redirect) begin
                flush_end  = cyc + FC;
                after_load = 1'b0;
            end else if (inf) begin
                after_load = 1'b0;
            end else if (lu) begin
                after_load = 1'b1;
            end else begin
                iss = after_load || dec_valid;
                after_load = 1'b0;
                if (iss) begin
                    m_issue = 1'b1;
                    m_a = fwd(dec_rs1, dec_rs1_used);
                    m_b = fwd(dec_rs2, dec_rs2_used);
                    r = '{v: 1'b1, rd: int'(dec_rd), we: dec_reg_we, ld: dec_load};
                end
            end
            hist_push(r);
        end
        cyc++;
    endfunction

    task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit we, input bit ld, input bit redir, input bit rst);
        @(posedge clk);
        #1;
        if (!prev_stall) begin
            dec_valid    = v;
            dec_rs1      = rs1[4:0];
            dec_rs2      = rs2[4:0];
            dec_rs1_used = u1;
            dec_rs2_used = u2;
            dec_rd       = rd[4:0];
            dec_reg_we   = we;
            dec_load     = ld;
        end
        redirect = redir;
        reset    = rst;
        model_step();
    endtask

    task automatic ins(input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit we, input bit ld);
        step(1'b1, rs1, rs2, u1, u2, rd, we, ld, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("issue", 32'(issue), 32'(e.issue));
                check("flush", 32'(flush), 32'(e.flush));
                check("stall", 32'(stall), 32'(e.stall));
                if (e.chk_src) begin
                    check("alu_a_src", 32'(alu_a_src), 32'(e.a));
                    check("alu_b_src", 32'(alu_b_src), 32'(e.b));
                end
`ifdef HAZARD_PERF_EN
                check("perf_stall_cnt", perf_stall_cnt, 32'(e.sc));
                check("perf_flush_cnt", perf_flush_cnt, 32'(e.fc));
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        model_reset();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        ins(0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        ins(1, 3, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        idle(2);

        ins(0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        ins(9, 10, 1'b1, 1'b1, 11, 1'b1, 1'b0);
        ins(1, 3, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        idle(2);

        ins(0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
        ins(5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        idle(3);

        ins(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        ins(0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        idle(2);

        step(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) ins(1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);

        step(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        ins(1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        step(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) ins(1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);

        ins(0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b1);
        step(1'b1, 7, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) ins(7, 8, 1'b1, 1'b1, 9, 1'b1, 1'b0);

        step(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        ins(1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        step(1'b1, 1, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) ins(4, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(3);

        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
